// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx: stereo PCM to I2S serialiser with a 1-entry sample buffer
// and a fractional bit-clock generator, so any clk_sys rate can be used.
//
// Ports:
//   clk_sys, reset      system clock, synchronous active-high reset
//   sample_l/_r         AUDIO_DW-bit two's complement samples
//   sample_valid/ready  pair handshake into the 1-entry buffer
//   frame_start         1-cycle pulse on each 64-bit frame load
//   underrun            1-cycle pulse when a load found the buffer empty
//   i2s_bck/lrck/data   serial audio; receivers sample on BCK rise
//
// Build option I2S_LJ_FORMAT_EN: left-justified output (lrck high for the
// left slot, no one-bit data delay). Default is Philips I2S.

module i2s_audio_tx #(
  parameter int CLK_RATE    = 32000000,
  parameter int SAMPLE_RATE = 48000,
  parameter int AUDIO_DW    = 16
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic [AUDIO_DW-1:0] sample_l,
  input  logic [AUDIO_DW-1:0] sample_r,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                frame_start,
  output logic                underrun,
  output logic                i2s_bck,
  output logic                i2s_lrck,
  output logic                i2s_data
);

  localparam int AW  = $clog2(CLK_RATE) + 1;
  localparam int PAD = 32 - AUDIO_DW;

  localparam logic [AW:0] INC =
    (AW+1)'(128 * SAMPLE_RATE);
  localparam logic [AW:0] LIM =
    (AW+1)'(CLK_RATE);

`ifdef I2S_LJ_FORMAT_EN
  localparam logic LRCK_RST = 1'b0;
`else
  localparam logic LRCK_RST = 1'b1;
`endif

  logic [AW-1:0]       acc;
  logic [AW-1:0]       acc_nxt;
  logic [AW:0]         sum;
  logic                tick;
  logic                fall;
  logic                wrap;
  logic                accept;
  logic [5:0]          bit_cnt;
  logic [5:0]          bit_nxt;
  logic                bck;
  logic                lrck;
  logic                lrck_nxt;
  logic                data;
  logic                data_nxt;
  logic                buf_full;
  logic                fs_q;
  logic                ur_q;
  logic [AUDIO_DW-1:0] buf_l;
  logic [AUDIO_DW-1:0] buf_r;
  logic [63:0]         sh;
  logic [31:0]         slot_l;
  logic [31:0]         slot_r;

  // Phase accumulator: two ticks per BCK period, 128 per frame.
  always_comb begin
    sum     = {1'b0, acc} + INC;
    tick    = 1'b0;
    acc_nxt = sum[AW-1:0];
    if (sum >= LIM) begin
      tick    = 1'b1;
      acc_nxt = AW'(sum - LIM);
    end
  end

  assign fall    = tick & bck;
  assign wrap    = fall & (bit_cnt == 6'd63);
  assign bit_nxt = bit_cnt + 6'd1;
  assign accept  = sample_valid & ~buf_full;

  // Buffer still holds the last pair when empty,
  // so an underrun load simply repeats it.
  assign slot_l = 32'(buf_l) << PAD;
  assign slot_r = 32'(buf_r) << PAD;

  // sh[63] is the bit belonging to the current
  // bit_cnt; Philips mode emits it one BCK late.
`ifdef I2S_LJ_FORMAT_EN
  assign data_nxt = wrap ? slot_l[31] : sh[62];
  assign lrck_nxt = ~bit_nxt[5];
`else
  assign data_nxt = sh[63];
  assign lrck_nxt = bit_nxt[5];
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      acc      <= '0;
      bck      <= 1'b0;
      bit_cnt  <= 6'd63;
      lrck     <= LRCK_RST;
      data     <= 1'b0;
      sh       <= '0;
      buf_l    <= '0;
      buf_r    <= '0;
      buf_full <= 1'b0;
      fs_q     <= 1'b0;
      ur_q     <= 1'b0;
    end else begin
      acc  <= acc_nxt;
      fs_q <= wrap;
      ur_q <= wrap & ~buf_full;
      if (tick) begin
        bck <= ~bck;
      end
      if (fall) begin
        bit_cnt <= bit_nxt;
        lrck    <= lrck_nxt;
        data    <= data_nxt;
        if (wrap) begin
          sh <= {slot_l, slot_r};
        end else begin
          sh <= {sh[62:0], 1'b0};
        end
      end
      if (accept) begin
        buf_l    <= sample_l;
        buf_r    <= sample_r;
        buf_full <= 1'b1;
      end else if (wrap) begin
        buf_full <= 1'b0;
      end
    end
  end

  assign sample_ready = ~buf_full;
  assign frame_start  = fs_q;
  assign underrun     = ur_q;
  assign i2s_bck      = bck;
  assign i2s_lrck     = lrck;
  assign i2s_data     = data;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb_i2s_audio_tx: randomized bench for i2s_audio_tx with a
// behavioural frame/tick model (tick count = floor(k*128*SR/CLK)).

module tb_i2s_audio_tx;

  localparam int     DW  = 16;
  localparam longint CLK = 32000000;
  localparam longint INC = 128 * 48000;

`ifdef I2S_LJ_FORMAT_EN
  localparam logic LRCK_RST = 1'b0;
  localparam int   SKIP = 0;
  localparam logic [63:0] LR_PAT =
    {32'hFFFF_FFFF, 32'h0};
`else
  localparam logic LRCK_RST = 1'b1;
  localparam int   SKIP = 1;
  localparam logic [63:0] LR_PAT =
    {31'h0, 32'hFFFF_FFFF, 1'b0};
`endif

  localparam logic [5:0] RST_O =
    {1'b0, LRCK_RST, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [63:0] PUSH_W =
    {16'h8001, 16'h0, 16'h7FFE, 16'h0};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] sample_l = '0;
  logic [DW-1:0] sample_r = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic          frame_start;
  logic          underrun;
  logic          i2s_bck;
  logic          i2s_lrck;
  logic          i2s_data;
  logic [5:0]    obs;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  longint        k = 0;
  longint        m_F = 0;
  int            m_n = 63;
  bit            m_full = 0;
  logic [DW-1:0] m_pl = '0, m_pr = '0;
  logic [DW-1:0] m_ll = '0, m_lr = '0;
  logic [63:0]   cur_f = '0, prev_f = '0;
  logic          e_fs = 0, e_ur = 0;
  logic [5:0]    exp_o = '0;

  always #5 clk = ~clk;

  i2s_audio_tx #(
    .CLK_RATE   (32000000),
    .SAMPLE_RATE(48000),
    .AUDIO_DW   (DW)
  ) dut (
    .clk_sys     (clk),
    .reset       (reset),
    .sample_l    (sample_l),
    .sample_r    (sample_r),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .frame_start (frame_start),
    .underrun    (underrun),
    .i2s_bck     (i2s_bck),
    .i2s_lrck    (i2s_lrck),
    .i2s_data    (i2s_data)
  );

  assign obs = {i2s_bck, i2s_lrck, i2s_data,
                sample_ready, frame_start, underrun};

  function automatic logic [63:0] mk(
    input logic [DW-1:0] l,
    input logic [DW-1:0] r
  );
    return {l, 16'h0, r, 16'h0};
  endfunction

  // Smallest cycle count k with floor(k*INC/CLK) >= t.
  function automatic longint k_for(input longint t);
    return (t * CLK + INC - 1) / INC;
  endfunction

  // One clock: samples the inputs, advances the model,
  // returns #1 after the edge with exp_o valid.
  task automatic step();
    logic rs, vs, eb, el, ed;
    logic [DW-1:0] ls, rr;
    longint t0, t1, f0, f1, tt;
    bit ld, ac;
    rs = reset;
    vs = sample_valid;
    ls = sample_l;
    rr = sample_r;
    @(posedge clk);
    #1;
    if (rs) begin
      k = 0; m_full = 0;
      m_pl = '0; m_pr = '0;
      m_ll = '0; m_lr = '0;
      cur_f = '0; prev_f = '0;
      e_fs = 0; e_ur = 0;
    end else begin
      t0 = k * INC / CLK;
      k++;
      t1 = k * INC / CLK;
      f0 = t0 / 2;
      f1 = t1 / 2;
      ld = (f1 != f0) && ((f1 - 1) % 64 == 0);
      ac = vs && !m_full;
      e_fs = ld;
      e_ur = ld && !m_full;
      if (ld) begin
        if (m_full) begin
          m_ll = m_pl;
          m_lr = m_pr;
        end
        prev_f = cur_f;
        cur_f = mk(m_ll, m_lr);
        m_full = 0;
      end
      if (ac) begin
        m_pl = ls;
        m_pr = rr;
        m_full = 1;
      end
    end
    tt  = k * INC / CLK;
    m_F = tt / 2;
    m_n = int'((63 + m_F) % 64);
    eb  = (tt % 2) == 1;
    if (m_F == 0) begin
      el = LRCK_RST;
      ed = 1'b0;
    end else begin
`ifdef I2S_LJ_FORMAT_EN
      el = (m_n < 32);
      ed = cur_f[63 - m_n];
`else
      el = (m_n >= 32);
      ed = (m_n == 0) ? prev_f[0]
                      : cur_f[64 - m_n];
`endif
    end
    exp_o = {eb, el, ed, !m_full, e_fs, e_ur};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sample_valid = 1'b0;
    repeat (10) step();
    n_checks++;
    if (obs !== RST_O) begin
      n_errors++;
      $display("FAIL reset_outs got=%b want=%b",
               obs, RST_O);
    end
    n_checks++;
    if (i2s_lrck !== LRCK_RST) begin
      n_errors++;
      $display("FAIL reset_lrck got=%b want=%b",
               i2s_lrck, LRCK_RST);
    end
    n_checks++;
    if (sample_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_ready got=%b want=1",
               sample_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_push();
    bit got_fs;
    int rises;
    logic pb;
    logic [63:0] w, lw;
    sample_l = 16'h8001;
    sample_r = 16'h7FFE;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    n_checks++;
    if (obs !== exp_o) begin
      n_errors++;
      $display("FAIL push_accept k=%0d got=%b want=%b",
               k, obs, exp_o);
    end
    got_fs = 0; rises = 0; pb = i2s_bck;
    w = '0; lw = '0;
    for (int c = 0; c < 1600; c++) begin
      if (rises >= SKIP + 64) break;
      step();
      n_checks++;
      if (obs !== exp_o) begin
        n_errors++;
        $display("FAIL push_model k=%0d got=%b want=%b",
                 k, obs, exp_o);
      end
      if (frame_start && !got_fs) begin
        got_fs = 1;
        n_checks++;
        if (underrun !== 1'b0) begin
          n_errors++;
          $display("FAIL push_underrun got=%b want=0",
                   underrun);
        end
      end else if (got_fs && i2s_bck && !pb) begin
        if (rises >= SKIP) begin
          w  = {w[62:0], i2s_data};
          lw = {lw[62:0], i2s_lrck};
        end
        rises++;
      end
      pb = i2s_bck;
    end
    n_checks++;
    if (rises < SKIP + 64) begin
      n_errors++;
      $display("FAIL push_timeout rises=%0d want=%0d",
               rises, SKIP + 64);
    end
    n_checks++;
    if (w !== PUSH_W) begin
      n_errors++;
      $display("FAIL push_word got=%h want=%h",
               w, PUSH_W);
    end
    n_checks++;
    if (lw !== LR_PAT) begin
      n_errors++;
      $display("FAIL push_lrck got=%h want=%h",
               lw, LR_PAT);
    end
  endtask

  task automatic test_repeat();
    bit got_fs;
    int rises;
    logic pb;
    logic [63:0] w;
    sample_valid = 1'b0;
    got_fs = 0; rises = 0; pb = i2s_bck;
    w = '0;
    for (int c = 0; c < 2000; c++) begin
      if (rises >= SKIP + 64) break;
      step();
      n_checks++;
      if (obs !== exp_o) begin
        n_errors++;
        $display("FAIL repeat_model k=%0d got=%b want=%b",
                 k, obs, exp_o);
      end
      if (frame_start && !got_fs) begin
        got_fs = 1;
        n_checks++;
        if (underrun !== 1'b1) begin
          n_errors++;
          $display("FAIL repeat_underrun got=%b want=1",
                   underrun);
        end
      end else if (got_fs && i2s_bck && !pb) begin
        if (rises >= SKIP) w = {w[62:0], i2s_data};
        rises++;
      end
      pb = i2s_bck;
    end
    n_checks++;
    if (rises < SKIP + 64) begin
      n_errors++;
      $display("FAIL repeat_timeout rises=%0d want=%0d",
               rises, SKIP + 64);
    end
    n_checks++;
    if (w !== PUSH_W) begin
      n_errors++;
      $display("FAIL repeat_word got=%h want=%h",
               w, PUSH_W);
    end
  endtask

  task automatic test_back_to_back();
    int fs_seen, acc_cnt;
    bit pre;
    fs_seen = 0; acc_cnt = 0;
    sample_valid = 1'b1;
    for (int c = 0; c < 2800; c++) begin
      sample_l = DW'($urandom);
      sample_r = DW'($urandom);
      pre = sample_ready;
      step();
      if (pre) acc_cnt++;
      n_checks++;
      if (obs !== exp_o) begin
        n_errors++;
        $display("FAIL b2b_model k=%0d got=%b want=%b",
                 k, obs, exp_o);
      end
      if (frame_start) begin
        if (fs_seen > 0) begin
          n_checks++;
          if (acc_cnt != 1) begin
            n_errors++;
            $display("FAIL b2b_accepts got=%0d want=1",
                     acc_cnt);
          end
        end
        n_checks++;
        if (sample_ready !== 1'b1) begin
          n_errors++;
          $display("FAIL b2b_ready got=%b want=1",
                   sample_ready);
        end
        acc_cnt = 0;
        fs_seen++;
      end
    end
    sample_valid = 1'b0;
    n_checks++;
    if (fs_seen < 4) begin
      n_errors++;
      $display("FAIL b2b_frames got=%0d want>=4",
               fs_seen);
    end
  endtask

  task automatic test_mid_reset();
    bit found;
    int c1, c2, cnt;
    found = 0;
    sample_valid = 1'b1;
    sample_l = DW'($urandom);
    sample_r = DW'($urandom);
    for (int c = 0; c < 1500; c++) begin
      if (m_F > 0 && m_n == 20) begin
        found = 1;
        break;
      end
      step();
      n_checks++;
      if (obs !== exp_o) begin
        n_errors++;
        $display("FAIL mrst_model k=%0d got=%b want=%b",
                 k, obs, exp_o);
      end
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL mrst_seek got=%0d want=20", m_n);
    end
    sample_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (obs !== RST_O) begin
      n_errors++;
      $display("FAIL mrst_outs got=%b want=%b",
               obs, RST_O);
    end
    c1 = 0; c2 = 0; cnt = 0;
    for (int c = 1; c < 1500; c++) begin
      step();
      n_checks++;
      if (obs !== exp_o) begin
        n_errors++;
        $display("FAIL mrst_model2 k=%0d got=%b want=%b",
                 k, obs, exp_o);
      end
      if (frame_start) begin
        cnt++;
        if (cnt == 1) c1 = c;
        if (cnt == 2) begin
          c2 = c;
          break;
        end
      end
    end
    n_checks++;
    if (longint'(c1) != k_for(2)) begin
      n_errors++;
      $display("FAIL mrst_first got=%0d want=%0d",
               c1, k_for(2));
    end
    n_checks++;
    if (longint'(c2) != k_for(130)) begin
      n_errors++;
      $display("FAIL mrst_second got=%0d want=%0d",
               c2, k_for(130));
    end
  endtask

  task automatic test_rate();
    int fs_cnt, rise_cnt;
    logic pb;
    reset = 1'b1;
    sample_valid = 1'b0;
    repeat (10) step();
    reset = 1'b0;
    fs_cnt = 0; rise_cnt = 0; pb = 1'b0;
    for (int c = 0; c < 32000; c++) begin
      sample_valid = ($urandom_range(0, 3) == 0);
      sample_l = DW'($urandom);
      sample_r = DW'($urandom);
      step();
      n_checks++;
      if (obs !== exp_o) begin
        n_errors++;
        $display("FAIL rate_model k=%0d got=%b want=%b",
                 k, obs, exp_o);
      end
      if (frame_start) fs_cnt++;
      if (i2s_bck && !pb) rise_cnt++;
      pb = i2s_bck;
    end
    sample_valid = 1'b0;
    n_checks++;
    if (fs_cnt < 47 || fs_cnt > 49) begin
      n_errors++;
      $display("FAIL rate_frames got=%0d want=48",
               fs_cnt);
    end
    n_checks++;
    if (rise_cnt < 3071 || rise_cnt > 3073) begin
      n_errors++;
      $display("FAIL rate_bck got=%0d want=3072",
               rise_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_push();
    test_repeat();
    test_back_to_back();
    test_mid_reset();
    test_rate();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
